// File: rtl/uart_line_buffer_pkg.sv
// Shared character codes, FSM states and byte classification for the UART line buffer.
// Combinational helpers only.
package uart_line_buffer_pkg;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BYTE_DATA = 2'd0,
        BYTE_TERM = 2'd1,
        BYTE_BS   = 2'd2
    } byte_class_e;

    function automatic byte_class_e classify(input logic [7:0] b);
        byte_class_e c;
        c = BYTE_DATA;
        if ((b == ASCII_CR) || (b == ASCII_LF)) begin
            c = BYTE_TERM;
        end else if ((b == ASCII_BS) || (b == ASCII_DEL)) begin
            c = BYTE_BS;
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_line_buffer_byte_ram.sv
// Simple dual-port line RAM: synchronous write, registered read (1-cycle latency).
// Read register only updates when rd_en_i is high, so the output holds while stalled.
module uart_line_buffer_byte_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_reset_n,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_dat_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // The read register is reset so the transmit data port reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/uart_line_buffer.sv
// Line-editing buffer: stores rx bytes with backspace editing, replays the line to tx on terminator/full.
// tx_valid rises 2 cycles after the last write; one idle cycle between bytes; rx during replay is dropped.
module uart_line_buffer
    import uart_line_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          i_reset_n,
    input  logic [DW-1:0] i_rx_data,
    input  logic          i_rx_valid,
    output logic [DW-1:0] o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_busy,
    output logic [AW:0]   o_line_len,
    output logic          o_drop,
    output logic          o_overflow
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_e      state_q, state_d;
    logic [AW:0] count_q, count_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        tx_vld_q, tx_vld_d;
    logic        fetch_q, fetch_d;
    logic        drop_q, drop_d;
    logic        ovf_q, ovf_d;

    logic        ram_wr_en;
    logic        ram_rd_en;
    logic [DW-1:0] ram_rd_dat;
    byte_class_e rx_class;

    assign rx_class = classify(8'(i_rx_data));

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_FILL;
            count_q  <= '0;
            rd_ptr_q <= '0;
            tx_vld_q <= 1'b0;
            fetch_q  <= 1'b0;
            drop_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            tx_vld_q <= tx_vld_d;
            fetch_q  <= fetch_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        tx_vld_d  = tx_vld_q;
        fetch_d   = fetch_q;
        drop_d    = 1'b0;
        ovf_d     = ovf_q;
        ram_wr_en = 1'b0;
        ram_rd_en = 1'b0;

        unique case (state_q)
            ST_FILL: begin
                if (i_rx_valid) begin
                    unique case (rx_class)
                        BYTE_BS: begin
                            if (count_q != '0) begin
                                count_d = count_q - 1'b1;
                            end
                        end
                        BYTE_TERM: begin
                            ram_wr_en = 1'b1;
                            count_d   = count_q + 1'b1;
                            state_d   = ST_DRAIN;
                        end
                        default: begin
                            ram_wr_en = 1'b1;
                            count_d   = count_q + 1'b1;
                            if (count_q == LAST_IDX) begin
                                state_d = ST_DRAIN;
                                ovf_d   = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_DRAIN: begin
                drop_d = i_rx_valid;
                if (tx_vld_q) begin
                    if (i_tx_ready) begin
                        tx_vld_d = 1'b0;
                        if (rd_ptr_q == count_q - 1'b1) begin
                            state_d  = ST_FILL;
                            count_d  = '0;
                            rd_ptr_d = '0;
                            fetch_d  = 1'b0;
                        end else begin
                            // Prefetch the next byte on the transfer edge so the gap is one cycle.
                            rd_ptr_d  = rd_ptr_q + 1'b1;
                            ram_rd_en = 1'b1;
                            fetch_d   = 1'b1;
                        end
                    end
                end else if (fetch_q) begin
                    tx_vld_d = 1'b1;
                    fetch_d  = 1'b0;
                end else begin
                    ram_rd_en = 1'b1;
                    fetch_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    uart_line_buffer_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (count_q[AW-1:0]),
        .wr_dat_i  (i_rx_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_ptr_d[AW-1:0]),
        .rd_dat_o  (ram_rd_dat)
    );

    assign o_tx_data  = ram_rd_dat;
    assign o_tx_valid = tx_vld_q;
    assign o_busy     = (state_q == ST_DRAIN);
    assign o_line_len = count_q;
    assign o_drop     = drop_q;
    assign o_overflow = ovf_q;

endmodule
